// File: rtl/match_counter_pkg.sv
// Shared types and constants for the match_counter slice.
//   snap_state_t     : snapshot handshake FSM encoding
//   DEFAULT_NUM_BITS : default width of the count, wrap and snapshot fields
package match_pkg;

   localparam int DEFAULT_NUM_BITS = 8;

   typedef enum logic [0:0] {
      SNAP_IDLE = 1'b0,
      SNAP_HOLD = 1'b1
   } snap_state_t;

endpackage

// File: rtl/match_counter_rollover_counter.sv
// Modulo detection counter with a run-time wrap point.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear          : synchronous clear of count and flag
//   count_enable   : one count event (match_in already qualified)
//   rollover_val   : wrap point, sampled every cycle; 0 disables counting
//   count_out      : registered count
//   rollover_flag  : registered, high while count_out == rollover_val (nonzero)
//   wrap_pulse     : combinational, high in the cycle whose event wraps the
//                    count, so the parent can update its wrap register on the
//                    same edge as count_out
module rollover_counter
   import match_pkg::*;
#(
   parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                count_enable,
   input  logic [NUM_BITS-1:0] rollover_val,
   output logic [NUM_BITS-1:0] count_out,
   output logic                rollover_flag,
   output logic                wrap_pulse
);

   logic [NUM_BITS-1:0] count_q, count_d;
   logic                flag_q, flag_d;
   logic                rv_nonzero;

   assign rv_nonzero = (rollover_val != '0);

   always_comb begin
      count_d    = count_q;
      flag_d     = 1'b0;
      wrap_pulse = 1'b0;
      if (clear) begin
         count_d = '0;
      end else begin
         if (count_enable && rv_nonzero) begin
            // >= rather than == so a wrap point lowered below the current
            // count still wraps instead of running up to all-ones
            if (count_q >= rollover_val) begin
               count_d    = {{(NUM_BITS-1){1'b0}}, 1'b1};
               wrap_pulse = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         // re-evaluated every edge so a changed wrap point updates the flag
         // even without a count event
         flag_d = (count_d == rollover_val) && rv_nonzero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         flag_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         flag_q  <= flag_d;
      end
   end

   assign count_out     = count_q;
   assign rollover_flag = flag_q;

endmodule

// File: rtl/match_counter.sv
// Counts "1101" detector hits modulo a run-time wrap point, tracks the number
// of wraps (saturating) and offers a req/ack snapshot of {count, wraps}.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   clear               : clears count, wraps and flag (not the snapshot)
//   count_enable        : gates counting
//   match_in            : detector output, one detection per high cycle
//   rollover_val        : wrap point
//   count_out           : current count
//   rollover_flag       : high while count_out == rollover_val (nonzero)
//   wrap_count          : wraps seen, saturating at all-ones
//   snap_req / snap_ack : snapshot request / host consumed
//   snap_valid          : snapshot fields held and valid
//   snap_count/wraps    : captured count_out / wrap_count
module match_counter
   import match_pkg::*;
#(
   parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                count_enable,
   input  logic                match_in,
   input  logic [NUM_BITS-1:0] rollover_val,
   output logic [NUM_BITS-1:0] count_out,
   output logic                rollover_flag,
   output logic [NUM_BITS-1:0] wrap_count,
   input  logic                snap_req,
   output logic                snap_valid,
   input  logic                snap_ack,
   output logic [NUM_BITS-1:0] snap_count,
   output logic [NUM_BITS-1:0] snap_wraps
);

   // state     | meaning
   // SNAP_IDLE | no snapshot held; snap_req captures count/wraps
   // SNAP_HOLD | snapshot frozen and valid; waiting for snap_ack

   logic                count_event;
   logic                wrap_pulse;
   logic [NUM_BITS-1:0] wrap_count_q, wrap_count_d;
   snap_state_t         state_q, state_d;
   logic [NUM_BITS-1:0] snap_count_q, snap_count_d;
   logic [NUM_BITS-1:0] snap_wraps_q, snap_wraps_d;

   assign count_event = match_in & count_enable;

   rollover_counter #(
      .NUM_BITS (NUM_BITS)
   ) u_rollover_counter (
      .clk           (clk),
      .rst           (rst),
      .clear         (clear),
      .count_enable  (count_event),
      .rollover_val  (rollover_val),
      .count_out     (count_out),
      .rollover_flag (rollover_flag),
      .wrap_pulse    (wrap_pulse)
   );

   always_comb begin
      wrap_count_d = wrap_count_q;
      if (clear) begin
         wrap_count_d = '0;
      end else if (wrap_pulse && (wrap_count_q != '1)) begin
         wrap_count_d = wrap_count_q + 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      snap_count_d = snap_count_q;
      snap_wraps_d = snap_wraps_q;
      case (state_q)
         SNAP_IDLE: begin
            if (snap_req) begin
               // pre-update register values give a coherent pair
               snap_count_d = count_out;
               snap_wraps_d = wrap_count_q;
               state_d      = SNAP_HOLD;
            end
         end
         SNAP_HOLD: begin
            if (snap_ack) begin
               state_d = SNAP_IDLE;
            end
         end
         default: state_d = SNAP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrap_count_q <= '0;
         state_q      <= SNAP_IDLE;
         snap_count_q <= '0;
         snap_wraps_q <= '0;
      end else begin
         wrap_count_q <= wrap_count_d;
         state_q      <= state_d;
         snap_count_q <= snap_count_d;
         snap_wraps_q <= snap_wraps_d;
      end
   end

   assign wrap_count = wrap_count_q;
   assign snap_valid = (state_q == SNAP_HOLD);
   assign snap_count = snap_count_q;
   assign snap_wraps = snap_wraps_q;

endmodule

// File: tb/tb_match_counter.sv
module tb_match_counter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // 8-bit instance
   logic       rst = 1'b0, clear = 1'b0, count_enable = 1'b0, match_in = 1'b0;
   logic [7:0] rollover_val = '0;
   logic       snap_req = 1'b0, snap_ack = 1'b0;
   logic [7:0] count_out, wrap_count, snap_count, snap_wraps;
   logic       rollover_flag, snap_valid;

   // 4-bit instance for saturation
   logic       rst_4 = 1'b0, clear_4 = 1'b0, match_4 = 1'b0;
   logic [3:0] rv_4 = 4'd1;
   logic [3:0] count_4, wraps_4, snap_count_4, snap_wraps_4;
   logic       flag_4, snap_valid_4;

   match_counter #(.NUM_BITS(8)) dut (
      .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable),
      .match_in(match_in), .rollover_val(rollover_val),
      .count_out(count_out), .rollover_flag(rollover_flag),
      .wrap_count(wrap_count), .snap_req(snap_req), .snap_valid(snap_valid),
      .snap_ack(snap_ack), .snap_count(snap_count), .snap_wraps(snap_wraps)
   );

   match_counter #(.NUM_BITS(4)) dut_4 (
      .clk(clk), .rst(rst_4), .clear(clear_4), .count_enable(1'b1),
      .match_in(match_4), .rollover_val(rv_4),
      .count_out(count_4), .rollover_flag(flag_4),
      .wrap_count(wraps_4), .snap_req(1'b0), .snap_valid(snap_valid_4),
      .snap_ack(1'b0), .snap_count(snap_count_4), .snap_wraps(snap_wraps_4)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic [7:0] count;
      logic       flag;
      logic [7:0] wraps;
      logic       sv;
      logic [7:0] sc;
      logic [7:0] sw;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] sb4[$];

   // reference state for the 8-bit instance
   logic [7:0] m_count = '0, m_wraps = '0, m_sc = '0, m_sw = '0;
   logic       m_flag = 1'b0, m_hold = 1'b0;

   task automatic model(input logic r, c, e, m, input logic [7:0] v, input logic q, a);
      logic [7:0] nc, nw;
      exp_t x;
      if (r) begin
         m_count = '0; m_wraps = '0; m_flag = 1'b0; m_hold = 1'b0;
         m_sc = '0; m_sw = '0;
      end else begin
         nc = m_count;
         nw = m_wraps;
         if (c) begin
            nc = '0; nw = '0;
         end else if (e && m && v != 0) begin
            if (m_count < v) nc = m_count + 8'd1;
            else begin
               nc = 8'd1;
               if (m_wraps != 8'hFF) nw = m_wraps + 8'd1;
            end
         end
         if (!m_hold && q) begin
            m_sc = m_count; m_sw = m_wraps; m_hold = 1'b1;
         end else if (m_hold && a) begin
            m_hold = 1'b0;
         end
         m_flag  = !c && (v != 0) && (nc == v);
         m_count = nc;
         m_wraps = nw;
      end
      x.count = m_count; x.flag = m_flag; x.wraps = m_wraps;
      x.sv = m_hold; x.sc = m_sc; x.sw = m_sw;
      sb.push_back(x);
   endtask

   task automatic step(input logic r, c, e, m, input logic [7:0] v, input logic q, a,
                       input string tag);
      exp_t x;
      rst = r; clear = c; count_enable = e; match_in = m; rollover_val = v;
      snap_req = q; snap_ack = a;
      model(r, c, e, m, v, q, a);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      check({tag, "_cnt"},   count_out,     x.count);
      check({tag, "_flag"},  rollover_flag, x.flag);
      check({tag, "_wraps"}, wrap_count,    x.wraps);
      check({tag, "_sv"},    snap_valid,    x.sv);
      check({tag, "_sc"},    snap_count,    x.sc);
      check({tag, "_sw"},    snap_wraps,    x.sw);
   endtask

   task automatic step4(input logic r, c, m, input logic [3:0] exp_w, input string tag);
      rst_4 = r; clear_4 = c; match_4 = m;
      sb4.push_back(exp_w);
      @(posedge clk);
      #1;
      check(tag, wraps_4, sb4.pop_front());
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] seq [5];
      logic [3:0] ew;
      seq[0] = 8'd1; seq[1] = 8'd2; seq[2] = 8'd3; seq[3] = 8'd1; seq[4] = 8'd2;

      // reset with activity on the inputs
      step(1, 0, 1, 1, 8'd3, 1, 0, "rst0");
      step(1, 0, 1, 1, 8'd3, 1, 0, "rst1");
      check("rst_cnt_zero", count_out, 0);
      check("rst_sv_zero", snap_valid, 0);
      step(0, 0, 0, 0, 8'd3, 0, 1, "idle_ack");

      // modulo 3 with isolated pulses
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 1, 8'd3, 0, 0, "t2_ev");
         check("t2_seq", count_out, seq[i]);
         check("t2_flag_seq", rollover_flag, seq[i] == 8'd3);
         step(0, 0, 1, 0, 8'd3, 0, 0, "t2_gap");
      end
      check("t2_wraps_end", wrap_count, 1);

      // rollover_val == 1, held match
      step(0, 1, 1, 0, 8'd1, 0, 0, "t3_clr");
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 1, 8'd1, 0, 0, "t3_hold");
         check("t3_cnt_one", count_out, 1);
         check("t3_flag_one", rollover_flag, 1);
      end
      check("t3_wraps", wrap_count, 3);
      step(0, 0, 0, 1, 8'd1, 0, 0, "t3_disabled");
      check("t3_dis_wraps", wrap_count, 3);

      // clear beats a simultaneous event
      step(0, 1, 0, 0, 8'd5, 0, 0, "t4_clr");
      step(0, 0, 1, 1, 8'd5, 0, 0, "t4_ev");
      step(0, 0, 1, 1, 8'd5, 0, 0, "t4_ev");
      check("t4_cnt2", count_out, 2);
      step(0, 1, 1, 1, 8'd5, 0, 0, "t4_clr_ev");
      check("t4_cnt0", count_out, 0);

      // rollover_val == 0 holds
      step(0, 0, 1, 1, 8'd0, 0, 0, "rv0_ev");
      check("rv0_cnt", count_out, 0);

      // snapshot
      for (int i = 0; i < 15; i++) step(0, 0, 1, 1, 8'd5, 0, 0, "t5_fill");
      check("t5_pre_cnt", count_out, 5);
      check("t5_pre_wraps", wrap_count, 2);
      step(0, 0, 1, 0, 8'd10, 1, 0, "t5_req");
      check("t5_sc5", snap_count, 5);
      check("t5_sw2", snap_wraps, 2);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'd10, 1, 0, "t5_run");
      check("t5_cnt8", count_out, 8);
      check("t5_sc_frozen", snap_count, 5);
      step(0, 0, 1, 0, 8'd10, 1, 1, "t5_ack_req");
      check("t5_sv_drop", snap_valid, 0);
      check("t5_no_recap", snap_count, 5);
      step(0, 0, 1, 0, 8'd10, 1, 0, "t5_req2");
      check("t5_sc8", snap_count, 8);
      step(0, 1, 1, 0, 8'd10, 0, 0, "t5_clr_hold");
      check("t5_sc_kept", snap_count, 8);
      step(0, 0, 1, 0, 8'd10, 0, 1, "t5_ack");
      step(0, 0, 1, 0, 8'd10, 0, 0, "t5_after_ack");

      // wrap point lowered below the count
      for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 8'd10, 0, 0, "low_fill");
      check("low_cnt7", count_out, 7);
      step(0, 0, 1, 1, 8'd4, 0, 0, "low_wrap");
      check("low_cnt1", count_out, 1);
      step(0, 0, 1, 0, 8'd1, 0, 0, "rv_change_flag");
      check("rv_change_flag1", rollover_flag, 1);

      // mid-operation reset
      step(1, 0, 1, 1, 8'd4, 1, 0, "mid_rst");

      // saturation on the 4-bit instance
      step4(1, 0, 0, 4'd0, "t6_rst");
      for (int k = 1; k <= 20; k++) begin
         ew = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
         step4(0, 0, 1, ew, "t6_sat");
      end
      step4(0, 1, 0, 4'd0, "t6_clr");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
